// File: rtl/crc16_pkg.sv
// Shared constants, FSM state type and the byte-wide CRC-16 step function
// for the crc16_parallel framing block.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    OUT_LO = 2'd2
  } crc16_state_e;

  // Eight MSB-first serial shift steps folded into one combinational update.
  function automatic logic [15:0] crc16_next_byte(input logic [15:0] crc,
                                                  input logic [7:0]  data,
                                                  input logic [15:0] poly);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 8; i > 0; i--) begin
      fb = c[15] ^ data[i-1];
      c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Purely combinational one-byte CRC-16 update.
module crc16_byte_step
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc16_next_byte(crc_i, data_i, POLY);
  end

endmodule

// File: rtl/crc16_parallel.sv
// Byte-parallel CRC-16 generator: passes data through while absorbing it,
// then appends the CRC high byte first on the same output.
module crc16_parallel
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY,
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       d_finish,
  input  logic [7:0] crc_in,
  output logic [7:0] crc_out
);

  crc16_state_e state_q, state_d;
  logic [15:0]  crc_q, crc_d;
  logic [7:0]   out_q, out_d;
  logic [15:0]  step_base;
  logic [15:0]  step_crc;

  // The load byte is always folded into INIT, never into a stale register.
  assign step_base = (state_q == CALC) ? crc_q : INIT;

  crc16_byte_step #(.POLY(POLY)) u_step (
    .crc_i  (step_base),
    .data_i (crc_in),
    .crc_o  (step_crc)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          crc_d   = step_crc;
          out_d   = crc_in;
          state_d = CALC;
        end else begin
          crc_d = INIT;
        end
      end
      CALC: begin
        if (d_finish) begin
          out_d   = crc_q[15:8];
          state_d = OUT_LO;
        end else begin
          crc_d = step_crc;
          out_d = crc_in;
        end
      end
      OUT_LO: begin
        out_d   = crc_q[7:0];
        crc_d   = INIT;
        state_d = IDLE;
      end
      default: begin
        crc_d   = INIT;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
    end
  end

  assign crc_out = out_q;

endmodule

// File: tb/tb_crc16_parallel.sv
// Self-checking bench for crc16_parallel: directed framing cases plus random
// messages checked against a polynomial long-division reference.
module tb_crc16_parallel;
  import crc16_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       d_finish = 1'b0;
  logic [7:0] crc_in = 8'h00;
  logic [7:0] crc_out;

  int tests = 0;
  int fails = 0;

  crc16_parallel #(.POLY(16'h8005), .INIT(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .d_finish (d_finish),
    .crc_in   (crc_in),
    .crc_out  (crc_out)
  );

  always #5 clk = ~clk;

  // CRC as remainder of M(x)*x^16 divided by the generator, init 0.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < msg.size() * 8 + 16; i++) begin
      b = 1'b0;
      if (i < msg.size() * 8) begin
        logic [7:0] byt;
        byt = msg[i / 8];
        b = byt[7 - (i % 8)];
      end
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ {1'b1, 16'h8005};
    end
    return rem[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    tests++;
    assert (crc_out === exp) else begin
      fails++;
      $error("FAIL %s: crc_out=%h expected=%h", tag, crc_out, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    tests++;
    assert (dut.state_q === IDLE) else begin
      fails++;
      $error("FAIL %s: state=%0d expected IDLE", tag, dut.state_q);
    end
  endtask

  // Drives a whole message; load_all keeps load high during CALC (must be ignored).
  task automatic run_msg(input string tag, input logic [7:0] msg[$],
                         input logic [15:0] exp_crc, input bit load_all,
                         input bit tail);
    for (int i = 0; i < msg.size(); i++) begin
      load     = (i == 0) || load_all;
      d_finish = 1'b0;
      crc_in   = msg[i];
      tick();
      check({tag, "_pass"}, msg[i]);
    end
    load     = load_all;
    d_finish = 1'b1;
    crc_in   = 8'($urandom);
    tick();
    check({tag, "_hi"}, exp_crc[15:8]);
    load     = 1'b0;
    d_finish = 1'b0;
    crc_in   = 8'($urandom);
    tick();
    check({tag, "_lo"}, exp_crc[7:0]);
    if (tail) begin
      tick();
      check({tag, "_zero"}, 8'h00);
      check_idle({tag, "_idle"});
    end
  endtask

  initial begin
    logic [7:0] m[$];
    logic [7:0] one[$];

    // Reset dominates load
    rst = 1'b1; load = 1'b1; crc_in = 8'hFF;
    tick(); check("rst_c1", 8'h00);
    tick(); check("rst_c2", 8'h00);
    check_idle("rst_state");
    rst = 1'b0; load = 1'b0;
    tick(); check("post_rst1", 8'h00);
    check_idle("post_rst_state");
    tick(); check("post_rst2", 8'h00);

    // Standard check string "123456789"
    m = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_msg("check", m, 16'hFEE8, 1'b0, 1'b1);

    one = {8'h01};
    run_msg("single01", one, 16'h8005, 1'b0, 1'b1);
    m = {8'h00};
    run_msg("zero", m, 16'h0000, 1'b0, 1'b1);

    // Back-to-back: load right in the cycle after OUT_LO
    run_msg("b2b_a", one, 16'h8005, 1'b0, 1'b0);
    run_msg("b2b_b", one, 16'h8005, 1'b0, 1'b1);

    // load held during CALC must not restart the message
    m = {8'h01, 8'h00};
    run_msg("noreload", m, 16'h8603, 1'b1, 1'b1);

    // Reset mid-message
    load = 1'b1; crc_in = 8'h01;
    tick(); check("mid_load", 8'h01);
    load = 1'b0; crc_in = 8'h5A;
    tick(); check("mid_pass", 8'h5A);
    rst = 1'b1; crc_in = 8'hC3;
    tick(); check("mid_rst", 8'h00);
    check_idle("mid_rst_state");
    rst = 1'b0;
    run_msg("after_rst", one, 16'h8005, 1'b0, 1'b1);

    // Random messages against the long-division reference
    for (int n = 0; n < 20; n++) begin
      logic [7:0] r[$];
      int len;
      r = {};
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) r.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", n), r, ref_crc(r), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc16_parallel.md
Name: crc16_parallel

Overview:
- Byte-parallel CRC-16 generator: absorbs one data byte per clock, then emits the 16-bit checksum as two bytes on the same 8-bit output.
- Sits at a byte-stream framing point: data passes through during computation, then the CRC is appended high byte first.
- Algorithm: polynomial 0x8005 (x^16+x^15+x^2+1), init 0x0000, MSB-first, no reflection, no final XOR (CRC-16/BUYPASS).

Parameters:
- POLY, 16'h8005, generator polynomial without the implicit x^16 term.
- INIT, 16'h0000, CRC register value at reset and at the start of each message.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  start of message; the crc_in byte in the same cycle is the first data byte.
- d_finish  input  1  end of message; the crc_in byte in this cycle is NOT absorbed.
- crc_in  input  8  data byte, bit 7 processed first.
- crc_out  output  8  registered output: data pass-through, then CRC high byte, then CRC low byte.

Behaviour:
- Reset (rst=1 at an edge, in any state): state=IDLE, crc_reg=INIT, crc_out=8'h00. Reset overrides all other inputs.
- States: IDLE, CALC, OUT_LO.
- IDLE:
  - load=1: crc_reg<=next(INIT,crc_in); crc_out<=crc_in; go to CALC.
  - Otherwise: crc_out<=8'h00; crc_reg<=INIT.
  - d_finish is ignored. If load and d_finish are both 1, load wins.
- CALC:
  - d_finish=0: crc_reg<=next(crc_reg,crc_in); crc_out<=crc_in (1-cycle pass-through latency).
  - d_finish=1: crc_out<=crc_reg[15:8]; crc_reg holds; go to OUT_LO.
  - load is ignored in CALC; there is no restart mid-message.
- OUT_LO: crc_out<=crc_reg[7:0]; crc_reg<=INIT; go to IDLE. Inputs are ignored.
- Latency: CRC high byte appears on crc_out at the edge after the d_finish cycle; low byte appears one cycle later; crc_out returns to 0 the cycle after that.
- next(c,d): result of eight MSB-first serial steps, computed combinationally in one cycle. For i = 7 down to 0: fb=c[15]^d[i]; c=(c<<1) ^ (fb ? POLY : 0).
- Minimum message length is one byte (the load byte).
- Unbounded message length is allowed; there is no counter overflow.
- All undefined state encodings recover to IDLE.

Decomposition:
- Package crc16_pkg: POLY/INIT constants, state enum type (IDLE, CALC, OUT_LO), and function crc16_next_byte(crc[15:0], data[7:0]).
- One natural sub-module: crc16_byte_step, a purely combinational wrapper around crc16_next_byte.
- The top holds the FSM, crc_reg and the crc_out register.

Test Plan:
- Reset: drive rst=1 for 2 cycles with load=1 and crc_in=8'hFF → crc_out=8'h00 and state IDLE after release. Then with load=0, crc_out stays 8'h00.
- Check string: load with 8'h31, then 8'h32..8'h39 on the next 8 cycles, then a d_finish cycle → crc_out shows 31..39 delayed by one cycle, then 8'hFE, then 8'hE8, then 8'h00.
- Single byte: load with 8'h01, then d_finish=1 next cycle → crc_out 8'h01, then 8'h80, then 8'h05.
- Zero byte: load with 8'h00, then d_finish → CRC bytes 8'h00, 8'h00.
- Back-to-back: after the previous message's OUT_LO, load the 8'h01 message again → identical 8'h80/8'h05, proving crc_reg re-initialises. Also load=1 during CALC does not restart: a 2-byte message 01,00 yields a CRC that is neither the single-01 nor the single-00 result.
- Reset mid-message: assert rst during CALC → crc_out=8'h00 and IDLE at the next edge; a following 8'h01 message still yields 8'h80/8'h05.
